// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding and
// register-index constants.
package pipe_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + ONE;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush,
// mul/div multi-cycle EX and dmem wait states, plus performance counters.
//
// state    | meaning
// RUN      | normal flow; single-cycle hazards resolved combinationally
// MEM_WAIT | whole pipe frozen until dmem_ready; ret_q holds resume state
// MD_WAIT  | front end held, EX/MEM bubbled until mul/div completes
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_ex_memread,
  input  logic [REG_IDX_W-1:0] id_ex_reg_rd,
  input  logic [REG_IDX_W-1:0] if_id_reg_rs1,
  input  logic [REG_IDX_W-1:0] if_id_reg_rs2,
  input  logic                 if_id_uses_rs1,
  input  logic                 if_id_uses_rs2,
  input  logic                 ex_branch_taken,
  input  logic                 ex_multicycle,
  input  logic                 muldiv_done,
  input  logic                 ex_mem_memreq,
  input  logic                 dmem_ready,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic                 id_ex_write,
  output logic                 id_ex_flush,
  output logic                 ex_mem_write,
  output logic                 ex_mem_flush,
  output logic                 mem_wb_write,
  output logic                 mem_wb_flush,
  output logic                 muldiv_start,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_events,
  output logic                 mem_timeout_err
);

  localparam logic [7:0] TIMEOUT = MEM_TIMEOUT[7:0];

  state_t     state_q, state_d, ret_q, ret_d, eff_state;
  logic [7:0] wait_q, wait_d, wait_inc;
  logic       done_seen_q, done_seen_d;
  logic       err_set, branch_ev, mem_hold, load_use;
  logic       pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, memwb_w, memwb_f, start;

  assign mem_hold = ex_mem_memreq && !dmem_ready;
  assign wait_inc = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
  assign load_use = id_ex_memread && (id_ex_reg_rd != REG_X0) &&
                    ((if_id_uses_rs1 && (if_id_reg_rs1 == id_ex_reg_rd)) ||
                     (if_id_uses_rs2 && (if_id_reg_rs2 == id_ex_reg_rd)));
  // On the release cycle the non-MEM stages follow the state being resumed.
  assign eff_state = (state_q == MEM_WAIT && dmem_ready) ? ret_q : state_q;

  always_comb begin
    {pc_w, ifid_w, idex_w, exmem_w, memwb_w} = 5'b11111;
    {ifid_f, idex_f, exmem_f, memwb_f, start} = 5'b00000;
    state_d     = eff_state;
    ret_d       = ret_q;
    wait_d      = wait_q;
    done_seen_d = done_seen_q;
    err_set     = 1'b0;
    branch_ev   = 1'b0;
    if (state_q == MEM_WAIT && dmem_ready)
      wait_d = '0;
    case (eff_state)
      MEM_WAIT: begin
        {pc_w, ifid_w, idex_w, exmem_w, memwb_w} = 5'b00000;
        memwb_f = 1'b1;
        wait_d  = wait_inc;
        err_set = (wait_inc == TIMEOUT);
        if (muldiv_done)
          done_seen_d = 1'b1;
      end
      RUN: begin
        if (mem_hold) begin
          {pc_w, ifid_w, idex_w, exmem_w, memwb_w} = 5'b00000;
          memwb_f = 1'b1;
          ret_d   = RUN;
          state_d = MEM_WAIT;
        end else if (ex_multicycle) begin
          {pc_w, ifid_w, idex_w} = 3'b000;
          exmem_f = 1'b1;
          start   = 1'b1;
          state_d = MD_WAIT;
        end else if (ex_branch_taken) begin
          ifid_f    = 1'b1;
          idex_f    = 1'b1;
          branch_ev = 1'b1;
        end else if (load_use) begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          idex_f = 1'b1;
        end
      end
      MD_WAIT: begin
        if (mem_hold) begin
          {pc_w, ifid_w, idex_w, exmem_w, memwb_w} = 5'b00000;
          memwb_f = 1'b1;
          ret_d   = MD_WAIT;
          state_d = MEM_WAIT;
          if (muldiv_done)
            done_seen_d = 1'b1;
        end else if (muldiv_done || done_seen_q) begin
          state_d     = RUN;
          done_seen_d = 1'b0;
        end else begin
          {pc_w, ifid_w, idex_w} = 3'b000;
          exmem_f = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= RUN;
      ret_q           <= RUN;
      wait_q          <= '0;
      done_seen_q     <= 1'b0;
      mem_timeout_err <= 1'b0;
    end else begin
      state_q         <= state_d;
      ret_q           <= ret_d;
      wait_q          <= wait_d;
      done_seen_q     <= done_seen_d;
      mem_timeout_err <= mem_timeout_err | err_set;
    end
  end

  // Controls are forced low while reset is asserted, independent of the clock.
  assign pc_write     = rst_n & pc_w;
  assign if_id_write  = rst_n & ifid_w;
  assign if_id_flush  = rst_n & ifid_f;
  assign id_ex_write  = rst_n & idex_w;
  assign id_ex_flush  = rst_n & idex_f;
  assign ex_mem_write = rst_n & exmem_w;
  assign ex_mem_flush = rst_n & exmem_f;
  assign mem_wb_write = rst_n & memwb_w;
  assign mem_wb_flush = rst_n & memwb_f;
  assign muldiv_start = rst_n & start;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!pc_w),
    .clr   (1'b0),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (branch_ev),
    .clr   (1'b0),
    .count (flush_events)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl; control bits are checked as
// {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, memwb_w, memwb_f, start}.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 32;
  localparam logic [9:0] C_RUN    = 10'b1101010100;
  localparam logic [9:0] C_LU     = 10'b0001110100;
  localparam logic [9:0] C_BR     = 10'b1111110100;
  localparam logic [9:0] C_MD_GO  = 10'b0000011101;
  localparam logic [9:0] C_MD     = 10'b0000011100;
  localparam logic [9:0] C_FREEZE = 10'b0000000010;
  localparam logic [9:0] C_RST    = 10'b0000000000;

  logic clk = 1'b0;
  logic rst_n;
  logic id_ex_memread, if_id_uses_rs1, if_id_uses_rs2;
  logic [4:0] id_ex_reg_rd, if_id_reg_rs1, if_id_reg_rs2;
  logic ex_branch_taken, ex_multicycle, muldiv_done, ex_mem_memreq, dmem_ready;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic ex_mem_write, ex_mem_flush, mem_wb_write, mem_wb_flush, muldiv_start;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic mem_timeout_err;
  logic [9:0] ctl;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                ex_mem_write, ex_mem_flush, mem_wb_write, mem_wb_flush, muldiv_start};

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_ex_memread(id_ex_memread), .id_ex_reg_rd(id_ex_reg_rd),
    .if_id_reg_rs1(if_id_reg_rs1), .if_id_reg_rs2(if_id_reg_rs2),
    .if_id_uses_rs1(if_id_uses_rs1), .if_id_uses_rs2(if_id_uses_rs2),
    .ex_branch_taken(ex_branch_taken), .ex_multicycle(ex_multicycle),
    .muldiv_done(muldiv_done), .ex_mem_memreq(ex_mem_memreq), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
    .ex_mem_write(ex_mem_write), .ex_mem_flush(ex_mem_flush),
    .mem_wb_write(mem_wb_write), .mem_wb_flush(mem_wb_flush),
    .muldiv_start(muldiv_start), .stall_cycles(stall_cycles),
    .flush_events(flush_events), .mem_timeout_err(mem_timeout_err)
  );

  task automatic idle_inputs();
    id_ex_memread = 0; id_ex_reg_rd = 0; if_id_reg_rs1 = 0; if_id_reg_rs2 = 0;
    if_id_uses_rs1 = 0; if_id_uses_rs2 = 0; ex_branch_taken = 0;
    ex_multicycle = 0; muldiv_done = 0; ex_mem_memreq = 0; dmem_ready = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    #2;
    vectors++;
    if (ctl !== C_RST || stall_cycles !== 0 || flush_events !== 0 || mem_timeout_err !== 0) begin
      miscompares++;
      $display("FAIL reset_state ctl=%b stall=%0d flush=%0d err=%b, required ctl=%b zeros",
               ctl, stall_cycles, flush_events, mem_timeout_err, C_RST);
    end
    @(negedge clk); rst_n = 1;
    step();
    @(negedge clk);
    vectors++;
    if (ctl !== C_RUN) begin
      miscompares++;
      $display("FAIL run_default ctl=%b required %b", ctl, C_RUN);
    end
  endtask

  task automatic test_load_use();
    step();
    id_ex_memread = 1; id_ex_reg_rd = 5; if_id_reg_rs1 = 5; if_id_reg_rs2 = 1;
    if_id_uses_rs1 = 1; if_id_uses_rs2 = 1;
    @(negedge clk);
    vectors++;
    if (ctl !== C_LU) begin
      miscompares++;
      $display("FAIL load_use_stall ctl=%b required %b", ctl, C_LU);
    end
    step();
    id_ex_memread = 0;
    @(negedge clk);
    vectors++;
    if (ctl !== C_RUN || stall_cycles !== 1) begin
      miscompares++;
      $display("FAIL load_use_release ctl=%b stall=%0d required ctl=%b stall=1", ctl, stall_cycles, C_RUN);
    end
    step();
    id_ex_memread = 1; id_ex_reg_rd = 0; if_id_reg_rs1 = 0; if_id_reg_rs2 = 0;
    @(negedge clk);
    vectors++;
    if (ctl !== C_RUN) begin
      miscompares++;
      $display("FAIL load_use_x0 ctl=%b required %b", ctl, C_RUN);
    end
    step();
    id_ex_reg_rd = 7; if_id_reg_rs1 = 3; if_id_reg_rs2 = 7; if_id_uses_rs2 = 0;
    @(negedge clk);
    vectors++;
    if (ctl !== C_RUN) begin
      miscompares++;
      $display("FAIL load_use_unused_rs2 ctl=%b required %b", ctl, C_RUN);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_branch();
    id_ex_memread = 1; id_ex_reg_rd = 9; if_id_reg_rs2 = 9; if_id_uses_rs2 = 1;
    ex_branch_taken = 1;
    @(negedge clk);
    vectors++;
    if (ctl !== C_BR) begin
      miscompares++;
      $display("FAIL branch_over_load_use ctl=%b required %b", ctl, C_BR);
    end
    step();
    idle_inputs();
    @(negedge clk);
    vectors++;
    if (flush_events !== 1 || stall_cycles !== 1 || ctl !== C_RUN) begin
      miscompares++;
      $display("FAIL branch_counters flush=%0d stall=%0d ctl=%b required 1 1 %b",
               flush_events, stall_cycles, ctl, C_RUN);
    end
  endtask

  task automatic test_muldiv();
    int starts;
    starts = 0;
    step();
    ex_multicycle = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      starts += int'(muldiv_start);
      vectors++;
      if (ctl !== ((c == 0) ? C_MD_GO : C_MD)) begin
        miscompares++;
        $display("FAIL muldiv_wait_c%0d ctl=%b required %b", c, ctl, (c == 0) ? C_MD_GO : C_MD);
      end
      step();
    end
    muldiv_done = 1;
    @(negedge clk);
    starts += int'(muldiv_start);
    vectors++;
    if (ctl !== C_RUN) begin
      miscompares++;
      $display("FAIL muldiv_done_cycle ctl=%b required %b", ctl, C_RUN);
    end
    step();
    idle_inputs();
    @(negedge clk);
    vectors++;
    if (starts !== 1 || stall_cycles !== 5 || ctl !== C_RUN) begin
      miscompares++;
      $display("FAIL muldiv_summary starts=%0d stall=%0d ctl=%b required 1 5 %b",
               starts, stall_cycles, ctl, C_RUN);
    end
  endtask

  task automatic test_back_to_back();
    step();
    ex_multicycle = 1;
    step();
    ex_mem_memreq = 1; dmem_ready = 0;
    @(negedge clk);
    vectors++;
    if (ctl !== C_FREEZE) begin
      miscompares++;
      $display("FAIL md_mem_freeze ctl=%b required %b", ctl, C_FREEZE);
    end
    step();
    muldiv_done = 1;
    @(negedge clk);
    vectors++;
    if (ctl !== C_FREEZE) begin
      miscompares++;
      $display("FAIL mem_wait_done_pulse ctl=%b required %b", ctl, C_FREEZE);
    end
    step();
    muldiv_done = 0;
    @(negedge clk);
    vectors++;
    if (ctl !== C_FREEZE) begin
      miscompares++;
      $display("FAIL mem_wait_hold ctl=%b required %b", ctl, C_FREEZE);
    end
    step();
    dmem_ready = 1;
    @(negedge clk);
    vectors++;
    if (ctl !== C_RUN) begin
      miscompares++;
      $display("FAIL mem_release_md_exit ctl=%b required %b", ctl, C_RUN);
    end
    step();
    idle_inputs();
    @(negedge clk);
    vectors++;
    if (ctl !== C_RUN || stall_cycles !== 9 || mem_timeout_err !== 0) begin
      miscompares++;
      $display("FAIL back_to_back_after ctl=%b stall=%0d err=%b required %b 9 0",
               ctl, stall_cycles, mem_timeout_err, C_RUN);
    end
  endtask

  task automatic test_timeout();
    step();
    ex_mem_memreq = 1; dmem_ready = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vectors++;
      if (ctl !== C_FREEZE || mem_timeout_err !== (c >= 5)) begin
        miscompares++;
        $display("FAIL timeout_c%0d ctl=%b err=%b required %b %b", c, ctl, mem_timeout_err, C_FREEZE, c >= 5);
      end
      step();
    end
    dmem_ready = 1;
    @(negedge clk);
    vectors++;
    if (ctl !== C_RUN || mem_timeout_err !== 1) begin
      miscompares++;
      $display("FAIL timeout_release ctl=%b err=%b required %b 1", ctl, mem_timeout_err, C_RUN);
    end
    step();
    idle_inputs();
    @(negedge clk);
    vectors++;
    if (mem_timeout_err !== 1 || stall_cycles !== 15) begin
      miscompares++;
      $display("FAIL timeout_sticky err=%b stall=%0d required 1 15", mem_timeout_err, stall_cycles);
    end
  endtask

  task automatic test_reset_in_md();
    step();
    ex_multicycle = 1;
    step();
    @(negedge clk);
    vectors++;
    if (ctl !== C_MD) begin
      miscompares++;
      $display("FAIL pre_reset_md ctl=%b required %b", ctl, C_MD);
    end
    #2 rst_n = 0;
    idle_inputs();
    #1;
    vectors++;
    if (ctl !== C_RST || stall_cycles !== 0 || flush_events !== 0 || mem_timeout_err !== 0) begin
      miscompares++;
      $display("FAIL async_reset ctl=%b stall=%0d flush=%0d err=%b required all zero",
               ctl, stall_cycles, flush_events, mem_timeout_err);
    end
    @(negedge clk); rst_n = 1;
    step();
    @(negedge clk);
    vectors++;
    if (ctl !== C_RUN || stall_cycles !== 0) begin
      miscompares++;
      $display("FAIL post_reset_run ctl=%b stall=%0d required %b 0", ctl, stall_cycles, C_RUN);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_muldiv();
    test_back_to_back();
    test_timeout();
    test_reset_in_md();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
